mdu: RTL and testbench

Multiply/divide unit for the P7 pipelined MIPS core. It sits in the E stage and executes the `MDU_op` codes produced by the instruction decoder: mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It owns the HI/LO registers and models fixed multi-cycle latency through a busy counter. The hazard unit uses its `start`/`busy` outputs to stall MDU-class instructions in D.

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_calc.sv | 75 +++++++
 rtl/mdu.sv | 108 ++++++++++
 tb/tb_mdu.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDU_* opcodes (same values as the core-wide const.v definitions)
//   - default latencies MDU_MUL_CYC / MDU_DIV_CYC
//   - FSM state type and opcode classification helpers
package mdu_pkg;

    localparam logic [4:0] MDU_none  = 5'd0;
    localparam logic [4:0] MDU_mult  = 5'd1;
    localparam logic [4:0] MDU_multu = 5'd2;
    localparam logic [4:0] MDU_div   = 5'd3;
    localparam logic [4:0] MDU_divu  = 5'd4;
    localparam logic [4:0] MDU_mthi  = 5'd5;
    localparam logic [4:0] MDU_mtlo  = 5'd6;
    localparam logic [4:0] MDU_mfhi  = 5'd7;
    localparam logic [4:0] MDU_mflo  = 5'd8;
    localparam logic [4:0] MDU_err   = 5'd31;

    localparam int MDU_MUL_CYC = 5;
    localparam int MDU_DIV_CYC = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    // Operations that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [4:0] op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == MDU_div) || (op == MDU_divu);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational datapath of the MDU.
//   op          : MDU opcode
//   a, b        : operands (rs, rt)
//   hi, lo      : current architectural HI/LO
//   p_hi, p_lo  : result to be committed later
// Multiplies produce the full 64-bit product; divides produce
// LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
// A zero divisor yields the current HI/LO, so the commit is a no-op.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] p_hi,
    output logic [31:0] p_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_raw;
    logic [31:0] r_raw;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Sign-extending to 64 bits makes the truncated product the signed result.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both divides: the signed case works on
    // magnitudes and restores signs afterwards. 0x80000000 / -1 falls out
    // naturally: magnitude quotient 0x80000000, negated back to 0x80000000.
    assign signed_div = (op == MDU_div);
    assign mag_a = a[31] ? (~a + 32'd1) : a;
    assign mag_b = b[31] ? (~b + 32'd1) : b;
    assign dvd   = signed_div ? mag_a : a;
    assign dvs   = signed_div ? mag_b : b;
    assign q_raw = (dvs != 32'd0) ? (dvd / dvs) : 32'd0;
    assign r_raw = (dvs != 32'd0) ? (dvd % dvs) : 32'd0;
    assign q_fix = (signed_div && (a[31] ^ b[31])) ? (~q_raw + 32'd1) : q_raw;
    assign r_fix = (signed_div && a[31]) ? (~r_raw + 32'd1) : r_raw;

    always_comb begin
        p_hi = hi;
        p_lo = lo;
        case (op)
            MDU_mult: begin
                p_hi = prod_s[63:32];
                p_lo = prod_s[31:0];
            end
            MDU_multu: begin
                p_hi = prod_u[63:32];
                p_lo = prod_u[31:0];
            end
            MDU_div, MDU_divu: begin
                if (b != 32'd0) begin
                    p_hi = r_fix;
                    p_lo = q_fix;
                end
            end
            default: begin
                p_hi = hi;
                p_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit for the E stage, owner of HI/LO.
//   clk, reset : clock and synchronous active-high reset
//   MDU_op     : E-stage MDU opcode
//   A, B       : forwarded rs / rt values
//   req        : exception/interrupt flush; blocks new starts and mthi/mtlo
//   start      : combinational, a long op is accepted this cycle
//   busy       : registered, an accepted op is in flight
//   MDU_out    : HI on mfhi, LO on mflo, else 0
// Results are computed at acceptance, parked in p_hi/p_lo, and committed to
// HI/LO on the last busy cycle so the fixed latency is modelled exactly.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_CYC = MDU_MUL_CYC,
    parameter int DIV_CYC = MDU_DIV_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  MDU_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] MDU_out
);

    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      p_hi_reg;
    logic [31:0]      p_lo_reg;
    logic             busy_reg;
    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             accept;

    mdu_calc u_calc (
        .op   (MDU_op),
        .a    (A),
        .b    (B),
        .hi   (hi_reg),
        .lo   (lo_reg),
        .p_hi (calc_hi),
        .p_lo (calc_lo)
    );

    assign accept = (state_reg == S_IDLE) && !req && is_long_op(MDU_op);
    assign start  = accept;
    assign busy   = busy_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            p_hi_reg  <= 32'd0;
            p_lo_reg  <= 32'd0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        p_hi_reg  <= calc_hi;
                        p_lo_reg  <= calc_lo;
                        cnt_reg   <= is_div_op(MDU_op) ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
                        state_reg <= S_RUN;
                        busy_reg  <= 1'b1;
                    end else if (!req && MDU_op == MDU_mthi) begin
                        hi_reg <= A;
                    end else if (!req && MDU_op == MDU_mtlo) begin
                        lo_reg <= A;
                    end
                end
                S_RUN: begin
                    // Everything arriving here is ignored; req does not cancel.
                    if (cnt_reg == CNT_W'(1)) begin
                        hi_reg    <= p_hi_reg;
                        lo_reg    <= p_lo_reg;
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (MDU_op)
            MDU_mfhi: MDU_out = hi_reg;
            MDU_mflo: MDU_out = lo_reg;
            default:  MDU_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. A cycle-accurate reference model
// (absolute cycle numbers + plain 64-bit arithmetic) predicts start, busy and
// MDU_out every cycle; a vector table and hand-written sequences add
// explicit checks of results, latencies and corner cases.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] MDU_out;

    mdu dut (
        .clk     (clk),
        .reset   (reset),
        .MDU_op  (MDU_op),
        .A       (A),
        .B       (B),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .MDU_out (MDU_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int          cyc = 0;
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pend;
    int          m_until;

    logic        seen_start, seen_busy;
    logic [31:0] seen_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_long(input logic [4:0] op);
        return op == MDU_mult || op == MDU_multu || op == MDU_div || op == MDU_divu;
    endfunction

    function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, pu;
        ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
        ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MDU_mult:  begin q = sa * sb; return q; end
            MDU_multu: begin pu = ua * ub; return pu; end
            MDU_div: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDU_divu: begin
                if (b == 32'd0) return {hi, lo};
                pu = ((ua % ub) << 32) | (ua / ub);
                return pu;
            end
            default: return {hi, lo};
        endcase
    endfunction

    // One clock cycle: drive, check predicted outputs, advance the model.
    task automatic cycle(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, input logic rst);
        logic        e_start;
        logic [31:0] e_out;
        logic [63:0] res;
        MDU_op = op; A = a; B = b; req = rq; reset = rst;
        #2;
        if (m_pend && cyc > m_until) begin
            m_hi = m_phi; m_lo = m_plo; m_pend = 1'b0;
        end
        e_start = !m_pend && !rq && model_long(op);
        e_out   = (op == MDU_mfhi) ? m_hi : (op == MDU_mflo) ? m_lo : 32'd0;
        seen_start = start; seen_busy = busy; seen_out = MDU_out;
        check("start", {31'd0, start}, {31'd0, e_start});
        check("busy",  {31'd0, busy},  {31'd0, m_pend});
        check("mdu_out", MDU_out, e_out);
        @(posedge clk);
        if (rst) begin
            m_hi = 0; m_lo = 0; m_pend = 1'b0;
        end else if (e_start) begin
            res     = ref_result(op, a, b, m_hi, m_lo);
            m_phi   = res[63:32];
            m_plo   = res[31:0];
            m_pend  = 1'b1;
            m_until = cyc + ((op == MDU_div || op == MDU_divu) ? 10 : 5);
        end else if (!m_pend && !rq) begin
            if (op == MDU_mthi) m_hi = a;
            if (op == MDU_mtlo) m_lo = a;
        end
        cyc++;
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cycle(MDU_none, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    localparam logic [31:0] PRE_HI = 32'h1111_1111;
    localparam logic [31:0] PRE_LO = 32'h2222_2222;

    initial begin
        int          bc;
        logic [4:0]  rops[11];
        logic [4:0]  rop;
        logic [31:0] rb;

        vecs[0] = '{MDU_mult,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MDU_multu, 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{MDU_div,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{MDU_divu,  32'hFFFFFFF9, 32'h2,        32'h00000001, 32'h7FFFFFFC, 10};
        vecs[4] = '{MDU_div,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5] = '{MDU_divu,  32'h7,        32'h0,        PRE_HI,       PRE_LO,       10};
        vecs[6] = '{MDU_div,   32'h7,        32'h0,        PRE_HI,       PRE_LO,       10};
        vecs[7] = '{MDU_mult,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[8] = '{MDU_div,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9] = '{MDU_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

        // Raw reset, then the model starts from the reset state.
        reset = 1'b1; MDU_op = MDU_none; A = 0; B = 0; req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pend = 1'b0; m_until = 0;
        reset = 1'b0;

        // Reset state and mthi.
        cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
        check("rst_hi", seen_out, 32'd0);
        check("rst_busy", {31'd0, seen_busy}, 32'd0);
        cycle(MDU_mthi, 32'h12345678, 0, 1'b0, 1'b0);
        check("mthi_busy", {31'd0, seen_busy}, 32'd0);
        cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
        check("mthi_read", seen_out, 32'h12345678);
        check("mthi_nobusy", {31'd0, seen_busy}, 32'd0);
        $display("seq reset/mthi done");

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            cycle(MDU_mthi, PRE_HI, 0, 1'b0, 1'b0);
            cycle(MDU_mtlo, PRE_LO, 0, 1'b0, 1'b0);
            cycle(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            check("vec_start", {31'd0, seen_start}, 32'd1);
            bc = 0;
            for (int k = 0; k < 20; k++) begin
                cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
                if (seen_busy) bc++;
                else break;
            end
            check("vec_latency", bc, vecs[i].lat);
            check("vec_hi", seen_out, vecs[i].exp_hi);
            cycle(MDU_mflo, 0, 0, 1'b0, 1'b0);
            check("vec_lo", seen_out, vecs[i].exp_lo);
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, bc);
        end

        // mult blocked by req.
        cycle(MDU_mthi, 32'hCAFE0001, 0, 1'b0, 1'b0);
        cycle(MDU_mult, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
        check("req_start", {31'd0, seen_start}, 32'd0);
        cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
        check("req_busy", {31'd0, seen_busy}, 32'd0);
        check("req_hi", seen_out, 32'hCAFE0001);
        $display("seq req-blocks-start done");

        // req during RUN does not cancel.
        cycle(MDU_mult, 32'd5, 32'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(MDU_none, 0, 0, 1'b1, 1'b0);
        cycle(MDU_mflo, 0, 0, 1'b0, 1'b0);
        check("req_run_lo", seen_out, 32'd30);
        $display("seq req-during-run done");

        // Reset in cycle 3 of a div discards the result.
        cycle(MDU_div, 32'd100, 32'd7, 1'b0, 1'b0);
        nop(2);
        cycle(MDU_none, 0, 0, 1'b0, 1'b1);
        cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
        check("rstrun_busy", {31'd0, seen_busy}, 32'd0);
        check("rstrun_hi", seen_out, 32'd0);
        nop(12);
        cycle(MDU_mflo, 0, 0, 1'b0, 1'b0);
        check("rstrun_lo", seen_out, 32'd0);
        $display("seq reset-during-div done");

        // Ops during RUN are ignored.
        cycle(MDU_mult, 32'd3, 32'd4, 1'b0, 1'b0);
        cycle(MDU_mtlo, 32'h0000AAAA, 0, 1'b0, 1'b0);
        cycle(MDU_mthi, 32'h0000BBBB, 0, 1'b0, 1'b0);
        cycle(MDU_div, 32'd9, 32'd3, 1'b0, 1'b0);
        check("run_div_start", {31'd0, seen_start}, 32'd0);
        cycle(MDU_multu, 32'd9, 32'd3, 1'b0, 1'b0);
        cycle(MDU_none, 0, 0, 1'b0, 1'b0);
        cycle(MDU_mflo, 0, 0, 1'b0, 1'b0);
        check("run_ign_lo", seen_out, 32'd12);
        cycle(MDU_mfhi, 0, 0, 1'b0, 1'b0);
        check("run_ign_hi", seen_out, 32'd0);
        $display("seq ops-during-run done");

        // Back-to-back: second mult in the first non-busy cycle.
        cycle(MDU_mult, 32'd2, 32'd3, 1'b0, 1'b0);
        nop(5);
        cycle(MDU_mult, 32'd4, 32'd5, 1'b0, 1'b0);
        check("b2b_start", {31'd0, seen_start}, 32'd1);
        check("b2b_busy", {31'd0, seen_busy}, 32'd0);
        nop(5);
        cycle(MDU_mflo, 0, 0, 1'b0, 1'b0);
        check("b2b_lo", seen_out, 32'd20);
        $display("seq back-to-back done");

        // Randomised traffic against the model.
        rops = '{MDU_none, MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mthi,
                 MDU_mtlo, MDU_mfhi, MDU_mflo, MDU_err, 5'd12};
        for (int i = 0; i < 800; i++) begin
            rop = rops[$urandom_range(10, 0)];
            rb  = ($urandom_range(7, 0) == 0) ? 32'd0 :
                  ($urandom_range(1, 0) == 1) ? $urandom : 32'($urandom_range(20, 0)) - 32'd10;
            cycle(rop, $urandom, rb, $urandom_range(5, 0) == 0, $urandom_range(149, 0) == 0);
        end
        $display("random traffic done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
